id_ex_issue: RTL and testbench

- ID/EX pipeline stage sitting directly upstream of the 64-bit ALU.
- Each cycle it does four things:
  - registers decoded instruction fields;
  - derives the 4-bit ALU_select from alu_op/opcode;
  - forwards EX/MEM and MEM/WB results onto the ALU operands;
  - detects load-use hazards and inserts a one-cycle bubble by stalling ID.
- Drives ALU data1/data2/ALU_select plus the control bits consumed by the EX/MEM register.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/id_ex_issue_operand_forward.sv | 31 +++
 rtl/id_ex_issue.sv | 135 +++++++++++++
 tb/tb_id_ex_issue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU function codes, alu_op encodings, R-type opcodes,
// datapath defaults and the ALU control decode used by the ID/EX stage.
package cpu_pkg;

  localparam int XLEN_DEF     = 64;
  localparam int RA_W_DEF     = 5;
  localparam int ZERO_REG_DEF = 31;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  typedef struct packed {
    logic [3:0] sel;
    logic       illegal;
  } alu_dec_t;

  // alu_op 11 is treated as add without raising the illegal flag.
  function automatic alu_dec_t alu_decode(input logic [1:0] op, input logic [10:0] opc);
    alu_dec_t d;
    d.sel     = ALU_ADD;
    d.illegal = 1'b0;
    case (op)
      ALUOP_PASSB: d.sel = ALU_PASSB;
      ALUOP_RTYPE: begin
        case (opc)
          OPC_ADD: d.sel = ALU_ADD;
          OPC_SUB: d.sel = ALU_SUB;
          OPC_AND: d.sel = ALU_AND;
          OPC_ORR: d.sel = ALU_ORR;
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.sel = ALU_ADD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_ex_issue_operand_forward.sv
// Per-operand forwarding mux: EX/MEM result beats MEM/WB data beats register file;
// the zero register is never forwarded.
module operand_forward
  import cpu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int RA_W     = RA_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic [RA_W-1:0] src_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic            ex_we_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            wb_we_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] data_o
);

  localparam logic [RA_W-1:0] ZR = RA_W'(ZERO_REG);

  always_comb begin
    data_o = rf_data_i;
    if (src_i != ZR) begin
      if (ex_we_i && (ex_rd_i == src_i))      data_o = ex_data_i;
      else if (wb_we_i && (wb_rd_i == src_i)) data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX issue register feeding the 64-bit ALU: ALU control decode, operand
// forwarding, and load-use stall with bubble insertion.
module id_ex_issue
  import cpu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int RA_W     = RA_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [1:0]      in_alu_op,
  input  logic [10:0]     in_opc,
  input  logic [RA_W-1:0] in_rn,
  input  logic [RA_W-1:0] in_rm,
  input  logic [RA_W-1:0] in_rd,
  input  logic [XLEN-1:0] in_rn_data,
  input  logic [XLEN-1:0] in_rm_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alu_src,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            in_reg_write,
  input  logic            in_mem_to_reg,
  input  logic            in_branch,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_data1,
  output logic [XLEN-1:0] alu_data2,
  output logic [3:0]      alu_select,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            illegal_op
);

  localparam logic [RA_W-1:0] ZR = RA_W'(ZERO_REG);

  logic            ex_valid_q, mem_read_q, mem_write_q, reg_write_q, mem_to_reg_q, branch_q;
  logic            illegal_q;
  logic [3:0]      alu_sel_q;
  logic [RA_W-1:0] rd_q, rn_q, rm_q;
  logic [XLEN-1:0] rn_data_q, rm_data_q, imm_q;
  logic            alu_src_q;

  logic            hazard, accept;
  alu_dec_t        dec_d;
  logic [XLEN-1:0] fwd_rn, fwd_rm;

  // Load-use check against the instruction currently sitting in EX.
  assign hazard = in_valid && ex_valid_q && mem_read_q && (rd_q != ZR) &&
                  ((rd_q == in_rn) || ((rd_q == in_rm) && (!in_alu_src || in_mem_write)));
  assign in_ready = rst || flush || !hazard;
  assign accept   = in_valid && !hazard && !flush;
  assign dec_d    = alu_decode(in_alu_op, in_opc);

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
      illegal_q    <= 1'b0;
      alu_sel_q    <= 4'b0000;
      rd_q         <= '0;
    end else begin
      ex_valid_q   <= accept;
      mem_read_q   <= accept && in_mem_read;
      mem_write_q  <= accept && in_mem_write;
      reg_write_q  <= accept && in_reg_write;
      mem_to_reg_q <= accept && in_mem_to_reg;
      branch_q     <= accept && in_branch;
      illegal_q    <= illegal_q || (accept && dec_d.illegal);
      if (accept) begin
        alu_sel_q <= dec_d.sel;
        rd_q      <= in_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rn_q      <= in_rn;
      rm_q      <= in_rm;
      rn_data_q <= in_rn_data;
      rm_data_q <= in_rm_data;
      imm_q     <= in_imm;
      alu_src_q <= in_alu_src;
    end
  end

  // ---- EX operand forwarding ----
  operand_forward #(.XLEN(XLEN), .RA_W(RA_W), .ZERO_REG(ZERO_REG)) u_fwd_rn (
    .src_i(rn_q), .rf_data_i(rn_data_q),
    .ex_we_i(exmem_reg_write), .ex_rd_i(exmem_rd), .ex_data_i(exmem_result),
    .wb_we_i(memwb_reg_write), .wb_rd_i(memwb_rd), .wb_data_i(memwb_data),
    .data_o(fwd_rn)
  );

  operand_forward #(.XLEN(XLEN), .RA_W(RA_W), .ZERO_REG(ZERO_REG)) u_fwd_rm (
    .src_i(rm_q), .rf_data_i(rm_data_q),
    .ex_we_i(exmem_reg_write), .ex_rd_i(exmem_rd), .ex_data_i(exmem_result),
    .wb_we_i(memwb_reg_write), .wb_rd_i(memwb_rd), .wb_data_i(memwb_data),
    .data_o(fwd_rm)
  );

  assign alu_data1     = fwd_rn;
  assign alu_data2     = alu_src_q ? imm_q : fwd_rm;
  assign ex_store_data = fwd_rm;
  assign alu_select    = alu_sel_q;
  assign ex_valid      = ex_valid_q;
  assign ex_rd         = rd_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_branch     = branch_q;
  assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: reset, decode, forwarding priority, load-use
// stall, flush and flush-during-stall, all against hand-computed values.
module tb_id_ex_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush;
  logic [1:0]  in_alu_op;
  logic [10:0] in_opc;
  logic [4:0]  in_rn, in_rm, in_rd;
  logic [63:0] in_rn_data, in_rm_data, in_imm;
  logic        in_alu_src, in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, in_branch;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [63:0] exmem_result, memwb_data;
  logic        ex_valid;
  logic [63:0] alu_data1, alu_data2, ex_store_data;
  logic [3:0]  alu_select;
  logic [4:0]  ex_rd;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, illegal_op;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_BAD = 11'b11111111111;

  always #5 clk = ~clk;

  id_ex_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .in_alu_op(in_alu_op), .in_opc(in_opc), .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
    .in_rn_data(in_rn_data), .in_rm_data(in_rm_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_branch(in_branch),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_select(alu_select), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .illegal_op(illegal_op)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] opc,
                       input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                       input logic [63:0] rnd, input logic [63:0] rmd, input logic [63:0] imm,
                       input logic src, input logic mr, input logic mw, input logic rw,
                       input logic m2r, input logic br);
    in_valid = v; in_alu_op = op; in_opc = opc;
    in_rn = rn; in_rm = rm; in_rd = rd;
    in_rn_data = rnd; in_rm_data = rmd; in_imm = imm;
    in_alu_src = src; in_mem_read = mr; in_mem_write = mw;
    in_reg_write = rw; in_mem_to_reg = m2r; in_branch = br;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 11'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic no_fwd();
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 64'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_data = 64'd0;
  endtask

  // LDUR X4, [X2, #8]
  task automatic drive_ldur_x4();
    drive(1'b1, 2'b00, 11'b11111000010, 5'd2, 5'd31, 5'd4, 64'h100, 64'd0, 64'd8,
          1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    no_fwd();
    drive(1'b1, 2'b10, OP_ADD, 5'd1, 5'd2, 5'd3, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ctrl", {ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch}, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_alu_sel", alu_select, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_in_ready", in_ready, 1);

    // SUB X1, X2, X3
    rst = 1'b0;
    drive(1'b1, 2'b10, OP_SUB, 5'd2, 5'd3, 5'd1, 64'd10, 64'd3, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("post_rst_not_yet", ex_valid, 0);
    tick();
    chk("sub_valid", ex_valid, 1);
    chk("sub_sel", alu_select, 4'b0110);
    chk("sub_d1", alu_data1, 64'd10);
    chk("sub_d2", alu_data2, 64'd3);
    chk("sub_rd", ex_rd, 5'd1);
    chk("sub_rw", ex_reg_write, 1);

    // Unknown R-type opcode
    drive(1'b1, 2'b10, OP_BAD, 5'd2, 5'd3, 5'd5, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bad_sel", alu_select, 4'b0010);
    chk("bad_flag", illegal_op, 1);
    idle();
    tick(); tick();
    chk("bad_sticky", illegal_op, 1);
    chk("idle_valid", ex_valid, 0);
    chk("idle_rw", ex_reg_write, 0);

    // CBZ-style pass-B, then add with immediate and alu_op 11
    drive(1'b1, 2'b01, 11'd0, 5'd9, 5'd8, 5'd31, 64'd7, 64'd55, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("cbz_sel", alu_select, 4'b0111);
    chk("cbz_br", ex_branch, 1);
    chk("cbz_d2", alu_data2, 64'd55);
    drive(1'b1, 2'b11, OP_SUB, 5'd9, 5'd8, 5'd10, 64'd7, 64'd55, 64'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("op11_sel", alu_select, 4'b0010);
    chk("imm_d2", alu_data2, 64'h1234);
    chk("store_data", ex_store_data, 64'd55);
    chk("st_mw", ex_mem_write, 1);
    chk("st_br_clear", ex_branch, 0);

    // Forward priority on rn = 5, rm = 6
    drive(1'b1, 2'b10, OP_ADD, 5'd5, 5'd6, 5'd9, 64'h11, 64'h22, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 64'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_data = 64'hBB;
    #1;
    chk("fwd_exmem_prio", alu_data1, 64'hAA);
    chk("fwd_rm_none", alu_data2, 64'h22);
    exmem_reg_write = 1'b0;
    #1;
    chk("fwd_memwb", alu_data1, 64'hBB);
    memwb_rd = 5'd6;
    #1;
    chk("fwd_rm_memwb", alu_data2, 64'hBB);
    chk("fwd_store", ex_store_data, 64'hBB);
    chk("fwd_rn_rf", alu_data1, 64'h11);
    drive(1'b1, 2'b10, OP_ADD, 5'd31, 5'd31, 5'd9, 64'h33, 64'h44, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    exmem_reg_write = 1'b1; exmem_rd = 5'd31; exmem_result = 64'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd31; memwb_data = 64'hBB;
    #1;
    chk("fwd_xzr_rn", alu_data1, 64'h33);
    chk("fwd_xzr_rm", alu_data2, 64'h44);
    no_fwd();

    // Load-use: LDUR X4 then ADD X6, X4, X7
    drive_ldur_x4();
    tick();
    chk("ld_mr", ex_mem_read, 1);
    chk("ld_d1", alu_data1, 64'h100);
    drive(1'b1, 2'b10, OP_ADD, 5'd4, 5'd7, 5'd6, 64'd40, 64'd70, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall", in_ready, 0);
    tick();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_bubble_ctrl", {ex_mem_read, ex_reg_write, ex_mem_to_reg}, 0);
    chk("lu_release", in_ready, 1);
    tick();
    chk("lu_issue", ex_valid, 1);
    chk("lu_issue_rd", ex_rd, 5'd6);
    chk("lu_issue_d1", alu_data1, 64'd40);

    // rm = 4 with immediate operand: no stall
    drive_ldur_x4();
    tick();
    drive(1'b1, 2'b00, 11'd0, 5'd8, 5'd4, 5'd6, 64'd1, 64'd2, 64'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("imm_nostall", in_ready, 1);
    tick();
    chk("imm_issue", ex_valid, 1);
    chk("imm_issue_d2", alu_data2, 64'd16);

    // Store whose data is the loaded register still stalls
    drive_ldur_x4();
    tick();
    drive(1'b1, 2'b00, 11'd0, 5'd8, 5'd4, 5'd31, 64'd1, 64'd2, 64'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("st_stall", in_ready, 0);
    tick();
    chk("st_bubble", ex_valid, 0);
    tick();
    chk("st_issue", ex_mem_write, 1);

    // Plain flush: independent ADD in ID, load in EX
    drive_ldur_x4();
    tick();
    drive(1'b1, 2'b10, OP_ADD, 5'd9, 5'd10, 5'd11, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_ready", in_ready, 1);
    tick();
    flush = 1'b0;
    idle();
    chk("fl_valid", ex_valid, 0);
    chk("fl_rw", ex_reg_write, 0);
    tick();
    chk("fl_never", ex_valid, 0);

    // Flush coinciding with a load-use hazard
    drive_ldur_x4();
    tick();
    drive(1'b1, 2'b10, OP_ADD, 5'd4, 5'd7, 5'd6, 64'd40, 64'd70, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("flh_bubble", ex_valid, 0);
    tick();
    chk("flh_no_dup", ex_valid, 0);
    chk("flh_no_dup_rw", ex_reg_write, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
